// File: rtl/regfile_wb_arbiter_if.sv
// Regfile write-port arbitration bundle: pipeline writeback, MDU result/issue, decode busy queries.
// Perf counter outputs appear only when WB_ARB_PERF_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
);
  logic                  I_pipe_we;
  logic [REG_ADDR_W-1:0] I_pipe_waddr;
  logic [DATA_W-1:0]     I_pipe_wdata;
  logic                  O_pipe_stall;

  logic                  I_mdu_issue;
  logic [REG_ADDR_W-1:0] I_mdu_issue_rd;
  logic                  I_mdu_valid;
  logic [REG_ADDR_W-1:0] I_mdu_waddr;
  logic [DATA_W-1:0]     I_mdu_wdata;
  logic                  O_mdu_ready;

  logic                  O_rd_we;
  logic [REG_ADDR_W-1:0] O_rd_waddr;
  logic [DATA_W-1:0]     O_rd_wdata;

  logic [REG_ADDR_W-1:0] I_rs1_raddr;
  logic [REG_ADDR_W-1:0] I_rs2_raddr;
  logic [REG_ADDR_W-1:0] I_rd_qaddr;
  logic                  O_rs1_busy;
  logic                  O_rs2_busy;
  logic                  O_rd_busy;

`ifdef WB_ARB_PERF_EN
  logic [31:0]           O_perf_mdu_wait;
  logic [31:0]           O_perf_force;
`endif

  modport slave (
    input  I_pipe_we, I_pipe_waddr, I_pipe_wdata,
    input  I_mdu_issue, I_mdu_issue_rd, I_mdu_valid, I_mdu_waddr, I_mdu_wdata,
    input  I_rs1_raddr, I_rs2_raddr, I_rd_qaddr,
`ifdef WB_ARB_PERF_EN
    output O_perf_mdu_wait, O_perf_force,
`endif
    output O_pipe_stall, O_mdu_ready, O_rd_we, O_rd_waddr, O_rd_wdata,
    output O_rs1_busy, O_rs2_busy, O_rd_busy
  );

  modport master (
    output I_pipe_we, I_pipe_waddr, I_pipe_wdata,
    output I_mdu_issue, I_mdu_issue_rd, I_mdu_valid, I_mdu_waddr, I_mdu_wdata,
    output I_rs1_raddr, I_rs2_raddr, I_rd_qaddr,
`ifdef WB_ARB_PERF_EN
    input  O_perf_mdu_wait, O_perf_force,
`endif
    input  O_pipe_stall, O_mdu_ready, O_rd_we, O_rd_waddr, O_rd_wdata,
    input  O_rs1_busy, O_rs2_busy, O_rd_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between pipeline writeback and MDU; zero-latency grant, pipe stalled when MDU wins,
// MDU forced through after MAX_WAIT denied cycles; pending scoreboard for decode hazards. Optional perf: WB_ARB_PERF_EN.
module regfile_wb_arbiter #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]   r_wait_cnt;
  logic [REG_NUM-1:0] r_pending;

  logic w_pipe_req;
  logic w_mdu_req;
  logic w_force;
  logic w_grant_mdu;
  logic w_grant_pipe;

  // Everything is gated by reset so the regfile never sees a write while rst_n is low.
  assign w_pipe_req   = rst_n && bus.I_pipe_we && (bus.I_pipe_waddr != '0);
  assign w_mdu_req    = rst_n && bus.I_mdu_valid;
  assign w_force      = w_mdu_req && (r_wait_cnt >= CNT_W'(MAX_WAIT));
  assign w_grant_mdu  = w_mdu_req && (!w_pipe_req || w_force);
  assign w_grant_pipe = w_pipe_req && !w_grant_mdu;

  assign bus.O_mdu_ready  = w_grant_mdu;
  assign bus.O_pipe_stall = w_pipe_req && w_grant_mdu;
  assign bus.O_rd_we      = w_grant_pipe || (w_grant_mdu && (bus.I_mdu_waddr != '0));

  always_comb begin
    bus.O_rd_waddr = '0;
    bus.O_rd_wdata = {DATA_W{1'b0}};
    if (w_grant_mdu) begin
      bus.O_rd_waddr = bus.I_mdu_waddr;
      bus.O_rd_wdata = bus.I_mdu_wdata;
    end else if (w_grant_pipe) begin
      bus.O_rd_waddr = bus.I_pipe_waddr;
      bus.O_rd_wdata = bus.I_pipe_wdata;
    end
  end

  // A same-cycle commit un-busies the register; regfile write-through supplies the value.
  function automatic logic f_busy(input logic [REG_ADDR_W-1:0] a);
    return r_pending[a] && !(w_grant_mdu && (bus.I_mdu_waddr == a));
  endfunction

  assign bus.O_rs1_busy = f_busy(bus.I_rs1_raddr);
  assign bus.O_rs2_busy = f_busy(bus.I_rs2_raddr);
  assign bus.O_rd_busy  = f_busy(bus.I_rd_qaddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_grant_mdu || !w_mdu_req) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != CNT_W'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Issue is checked before commit so a new op on the same rd keeps ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending[0] <= 1'b0;
      for (int i = 1; i < REG_NUM; i++) begin
        if (bus.I_mdu_issue && (bus.I_mdu_issue_rd == REG_ADDR_W'(i)))
          r_pending[i] <= 1'b1;
        else if (w_grant_mdu && (bus.I_mdu_waddr == REG_ADDR_W'(i)))
          r_pending[i] <= 1'b0;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_perf_mdu_wait;
  logic [31:0] r_perf_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_mdu_wait <= '0;
      r_perf_force    <= '0;
    end else begin
      if (w_mdu_req && !w_grant_mdu && (r_perf_mdu_wait != 32'hFFFF_FFFF))
        r_perf_mdu_wait <= r_perf_mdu_wait + 32'd1;
      if (w_force && (r_perf_force != 32'hFFFF_FFFF))
        r_perf_force <= r_perf_force + 32'd1;
    end
  end

  assign bus.O_perf_mdu_wait = r_perf_mdu_wait;
  assign bus.O_perf_force    = r_perf_force;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus random stimulus for regfile_wb_arbiter, checked against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.REG_ADDR_W(5), .DATA_W(32)) bus();

  regfile_wb_arbiter #(
    .REG_NUM(32), .REG_ADDR_W(5), .DATA_W(32), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errs = 0;
  int checks = 0;

  // Reference state: how many cycles the current MDU result has been refused, and which regs await MDU.
  int m_wait = 0;
  bit m_pend[32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pipe_wants();
    return bus.I_pipe_we && (bus.I_pipe_waddr != 5'd0);
  endfunction

  // MDU owns the port when the pipeline is idle or when it has already been refused MAX_WAIT times.
  function automatic bit mdu_wins();
    if (!bus.I_mdu_valid) return 1'b0;
    if (!pipe_wants()) return 1'b1;
    return m_wait >= MAX_WAIT;
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (mdu_wins() && bus.I_mdu_waddr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic check_model(input string tag);
    bit gm, gp;
    logic [4:0] ea;
    logic [31:0] ed;
    gm = mdu_wins();
    gp = pipe_wants() && !gm;
    ea = gm ? bus.I_mdu_waddr : (gp ? bus.I_pipe_waddr : 5'd0);
    ed = gm ? bus.I_mdu_wdata : (gp ? bus.I_pipe_wdata : 32'd0);
    chk({tag, "_ready"}, 64'(bus.O_mdu_ready), 64'(gm));
    chk({tag, "_stall"}, 64'(bus.O_pipe_stall), 64'(pipe_wants() && gm));
    chk({tag, "_we"}, 64'(bus.O_rd_we), 64'(gp || (gm && bus.I_mdu_waddr != 5'd0)));
    chk({tag, "_waddr"}, 64'(bus.O_rd_waddr), 64'(ea));
    chk({tag, "_wdata"}, 64'(bus.O_rd_wdata), 64'(ed));
    chk({tag, "_rs1b"}, 64'(bus.O_rs1_busy), 64'(exp_busy(bus.I_rs1_raddr)));
    chk({tag, "_rs2b"}, 64'(bus.O_rs2_busy), 64'(exp_busy(bus.I_rs2_raddr)));
    chk({tag, "_rdb"}, 64'(bus.O_rd_busy), 64'(exp_busy(bus.I_rd_qaddr)));
  endtask

  task automatic model_update();
    bit gm;
    gm = mdu_wins();
    if (bus.I_mdu_valid && !gm) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else m_wait = 0;
    if (gm && bus.I_mdu_waddr != 5'd0) m_pend[bus.I_mdu_waddr] = 1'b0;
    if (bus.I_mdu_issue && bus.I_mdu_issue_rd != 5'd0) m_pend[bus.I_mdu_issue_rd] = 1'b1;
  endtask

  task automatic model_reset();
    m_wait = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.I_pipe_we = 0; bus.I_pipe_waddr = 0; bus.I_pipe_wdata = 0;
    bus.I_mdu_issue = 0; bus.I_mdu_issue_rd = 0;
    bus.I_mdu_valid = 0; bus.I_mdu_waddr = 0; bus.I_mdu_wdata = 0;
    bus.I_rs1_raddr = 0; bus.I_rs2_raddr = 0; bus.I_rd_qaddr = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, 64'(bus.O_rd_we), 64'd0);
    chk({tag, "_waddr"}, 64'(bus.O_rd_waddr), 64'd0);
    chk({tag, "_wdata"}, 64'(bus.O_rd_wdata), 64'd0);
    chk({tag, "_stall"}, 64'(bus.O_pipe_stall), 64'd0);
    chk({tag, "_ready"}, 64'(bus.O_mdu_ready), 64'd0);
    chk({tag, "_busy"}, 64'({bus.O_rs1_busy, bus.O_rs2_busy, bus.O_rd_busy}), 64'd0);
  endtask

  initial begin
    model_reset();
    idle();
    bus.I_pipe_we = 1; bus.I_pipe_waddr = 5'd5; bus.I_pipe_wdata = 32'hDEAD;
    bus.I_mdu_valid = 1; bus.I_mdu_waddr = 5'd6;
    #2;
    check_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pipeline alone writes straight through.
    idle();
    bus.I_pipe_we = 1; bus.I_pipe_waddr = 5'd5; bus.I_pipe_wdata = 32'h1234;
    @(negedge clk);
    check_model("pipe_only");
    chk("pipe_only_we_k", 64'(bus.O_rd_we), 64'd1);
    chk("pipe_only_data_k", 64'(bus.O_rd_wdata), 64'h1234);
    tick();

    // x0 pipe write is not a request, so the MDU gets the port.
    idle();
    bus.I_pipe_we = 1; bus.I_pipe_waddr = 5'd0; bus.I_pipe_wdata = 32'h5555;
    bus.I_mdu_valid = 1; bus.I_mdu_waddr = 5'd7; bus.I_mdu_wdata = 32'h7777;
    @(negedge clk);
    check_model("pipe_x0");
    chk("pipe_x0_ready_k", 64'(bus.O_mdu_ready), 64'd1);
    chk("pipe_x0_waddr_k", 64'(bus.O_rd_waddr), 64'd7);
    tick();

    // Starvation: denied four cycles, forced on the fifth.
    idle();
    tick();
    for (int c = 0; c < 6; c++) begin
      bus.I_pipe_we = 1; bus.I_pipe_waddr = 5'd3; bus.I_pipe_wdata = 32'hAAAA_0000 + 32'(c);
      bus.I_mdu_valid = 1; bus.I_mdu_waddr = 5'd9; bus.I_mdu_wdata = 32'h99;
      @(negedge clk);
      check_model("starve");
      chk("starve_ready_k", 64'(bus.O_mdu_ready), 64'(c == 4));
      chk("starve_stall_k", 64'(bus.O_pipe_stall), 64'(c == 4));
      chk("starve_waddr_k", 64'(bus.O_rd_waddr), (c == 4) ? 64'd9 : 64'd3);
      tick();
    end
    idle();
    tick();

    // Issue rd=12, busy from the next cycle until a same-cycle-bypassed commit.
    idle();
    bus.I_mdu_issue = 1; bus.I_mdu_issue_rd = 5'd12; bus.I_rs1_raddr = 5'd12;
    @(negedge clk);
    chk("issue12_c0_busy", 64'(bus.O_rs1_busy), 64'd0);
    tick();
    idle();
    bus.I_rs1_raddr = 5'd12; bus.I_rd_qaddr = 5'd12;
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      check_model("wait12");
      chk("wait12_busy_k", 64'(bus.O_rs1_busy), 64'd1);
      tick();
    end
    bus.I_mdu_valid = 1; bus.I_mdu_waddr = 5'd12; bus.I_mdu_wdata = 32'hC0DE;
    @(negedge clk);
    check_model("commit12");
    chk("commit12_busy_k", 64'(bus.O_rs1_busy), 64'd0);
    tick();
    bus.I_mdu_valid = 0;
    @(negedge clk);
    chk("after12_busy_k", 64'(bus.O_rs1_busy), 64'd0);
    tick();

    // Set-wins when issue and commit hit rd=4 together.
    idle();
    bus.I_mdu_issue = 1; bus.I_mdu_issue_rd = 5'd4;
    tick();
    bus.I_mdu_valid = 1; bus.I_mdu_waddr = 5'd4; bus.I_rs2_raddr = 5'd4;
    @(negedge clk);
    check_model("setclr4");
    tick();
    idle();
    bus.I_rs2_raddr = 5'd4;
    bus.I_mdu_issue = 1; bus.I_mdu_issue_rd = 5'd0;
    @(negedge clk);
    chk("setclr4_next_busy_k", 64'(bus.O_rs2_busy), 64'd1);
    tick();
    bus.I_mdu_issue = 0; bus.I_rd_qaddr = 5'd0;
    bus.I_mdu_valid = 1; bus.I_mdu_waddr = 5'd0;
    @(negedge clk);
    chk("x0_busy_k", 64'(bus.O_rd_busy), 64'd0);
    chk("mdu_x0_ready_k", 64'(bus.O_mdu_ready), 64'd1);
    chk("mdu_x0_we_k", 64'(bus.O_rd_we), 64'd0);
    check_model("mdu_x0");
    tick();
    bus.I_mdu_waddr = 5'd4;
    @(negedge clk);
    check_model("clear4");
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus.I_pipe_we      = ($urandom_range(0, 9) < 7);
      bus.I_pipe_waddr   = 5'($urandom_range(0, 7));
      bus.I_pipe_wdata   = $urandom;
      bus.I_mdu_valid    = ($urandom_range(0, 1) == 1);
      bus.I_mdu_waddr    = 5'($urandom_range(0, 7));
      bus.I_mdu_wdata    = $urandom;
      bus.I_mdu_issue    = ($urandom_range(0, 9) < 3);
      bus.I_mdu_issue_rd = 5'($urandom_range(0, 7));
      bus.I_rs1_raddr    = 5'($urandom_range(0, 7));
      bus.I_rs2_raddr    = ($urandom_range(0, 1) == 1) ? bus.I_mdu_waddr : 5'($urandom_range(0, 7));
      bus.I_rd_qaddr     = 5'($urandom_range(0, 7));
      @(negedge clk);
      check_model("rand");
      tick();
    end

    // Asynchronous reset in the middle of a starvation wait with x5/x12 pending.
    idle();
    bus.I_mdu_issue = 1; bus.I_mdu_issue_rd = 5'd5;
    tick();
    bus.I_mdu_issue_rd = 5'd12;
    tick();
    idle();
    for (int c = 0; c < 2; c++) begin
      bus.I_pipe_we = 1; bus.I_pipe_waddr = 5'd3; bus.I_pipe_wdata = 32'h3;
      bus.I_mdu_valid = 1; bus.I_mdu_waddr = 5'd20;
      bus.I_rs1_raddr = 5'd5; bus.I_rs2_raddr = 5'd12; bus.I_rd_qaddr = 5'd5;
      tick();
    end
    @(negedge clk);
    chk("pre_rst_busy_k", 64'({bus.O_rs1_busy, bus.O_rs2_busy}), 64'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    bus.I_pipe_we = 0;
    bus.I_mdu_valid = 1; bus.I_mdu_waddr = 5'd6; bus.I_mdu_wdata = 32'h66;
    @(negedge clk);
    chk("post_rst_ready_k", 64'(bus.O_mdu_ready), 64'd1);
    chk("post_rst_busy_k", 64'({bus.O_rs1_busy, bus.O_rs2_busy, bus.O_rd_busy}), 64'd0);
    check_model("post_rst");
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
